// File: rtl/regfile_signext_if.sv
// Decode-stage operand bus: two register read ports, the write-back write port
// and the immediate sign-extender lanes.
interface regfile_signext_if;
   logic [4:0]  read_addr_1;
   logic [4:0]  read_addr_2;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        write_enabled;
   logic [31:0] data_1;
   logic [31:0] data_2;
   logic [15:0] in;
   logic [31:0] out;

   modport master (
      output read_addr_1, read_addr_2, write_addr, write_data, write_enabled, in,
      input  data_1, data_2, out
   );

   modport slave (
      input  read_addr_1, read_addr_2, write_addr, write_data, write_enabled, in,
      output data_1, data_2, out
   );
endinterface

// File: rtl/regfile_signext.sv
// MIPS32 decode operand block: 32x32 register file (r0 hardwired to zero) with
// combinational write-through reads, plus a 16-to-32-bit immediate sign extender.
module regfile_signext (
   input  logic             clk,
   input  logic             rst,
   regfile_signext_if.slave bus
);
   // Register contents packed so each generated register owns its own slice.
   logic [32*32-1:0] regs_flat;
   logic             write_ok;
   logic [31:0]      data_1_next;
   logic [31:0]      data_2_next;

   assign write_ok = rst && bus.write_enabled && (bus.write_addr != 5'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign regs_flat[gi*32 +: 32] = 32'h0;
         end else begin : g_gpr
            logic [31:0] value_reg;

            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  value_reg <= 32'h0;
               end else if (write_ok && (bus.write_addr == 5'(gi))) begin
                  value_reg <= bus.write_data;
               end
            end

            assign regs_flat[gi*32 +: 32] = value_reg;
         end
      end
   endgenerate

   // Bypass makes a same-cycle write visible, as if written in the first half-cycle.
   always_comb begin
      data_1_next = 32'h0;
      data_2_next = 32'h0;
      if (rst) begin
         if (write_ok && (bus.read_addr_1 == bus.write_addr)) begin
            data_1_next = bus.write_data;
         end else begin
            data_1_next = regs_flat[{bus.read_addr_1, 5'b00000} +: 32];
         end
         if (write_ok && (bus.read_addr_2 == bus.write_addr)) begin
            data_2_next = bus.write_data;
         end else begin
            data_2_next = regs_flat[{bus.read_addr_2, 5'b00000} +: 32];
         end
      end
   end

   assign bus.data_1 = data_1_next;
   assign bus.data_2 = data_2_next;
   assign bus.out    = {{16{bus.in[15]}}, bus.in};
endmodule

// File: tb/tb_regfile_signext.sv
// Directed bench for regfile_signext: reset, write/read, r0, bypass and sign extension.
module tb_regfile_signext;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   regfile_signext_if bus ();

   regfile_signext dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.write_addr    = addr;
      bus.write_data    = data;
      bus.write_enabled = 1'b1;
      @(posedge clk);
      #1;
      bus.write_enabled = 1'b0;
      $display("WR r%0d <= %h (rst=%0b)", addr, data, rst);
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      bus.read_addr_1 = a1;
      bus.read_addr_2 = a2;
      #1;
   endtask

   logic [15:0] ext_in  [5];
   logic [31:0] ext_exp [5];

   initial begin
      checks   = 0;
      failures = 0;
      ext_in[0] = 16'h0000; ext_exp[0] = 32'h00000000;
      ext_in[1] = 16'h0001; ext_exp[1] = 32'h00000001;
      ext_in[2] = 16'h7FFF; ext_exp[2] = 32'h00007FFF;
      ext_in[3] = 16'h8000; ext_exp[3] = 32'hFFFF8000;
      ext_in[4] = 16'hFFFF; ext_exp[4] = 32'hFFFFFFFF;

      rst               = 1'b0;
      bus.read_addr_1   = 5'd0;
      bus.read_addr_2   = 5'd0;
      bus.write_addr    = 5'd0;
      bus.write_data    = 32'h0;
      bus.write_enabled = 1'b0;
      bus.in            = 16'h0;
      repeat (2) @(posedge clk);
      #1;

      // Reset-state reads and extender while held in reset
      rd(5'd1, 5'd31);
      check("reset_d1", bus.data_1, 32'h0);
      check("reset_d2", bus.data_2, 32'h0);
      for (int i = 0; i < 5; i++) begin
         bus.in = ext_in[i];
         #1;
         check("sext_in_reset", bus.out, ext_exp[i]);
      end

      @(negedge clk);
      rst = 1'b1;

      // Fill r1..r31 with A000_00ii
      for (int i = 1; i < 32; i++) wr(5'(i), 32'hA0000000 + 32'(i));
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         check("fill_d1", bus.data_1, (i == 0) ? 32'h0 : 32'hA0000000 + 32'(i));
         check("fill_d2", bus.data_2, (i == 31) ? 32'h0 : 32'hA0000000 + 32'(31 - i));
      end

      // Asynchronous reset mid-cycle: contents vanish without a clock edge
      @(posedge clk);
      #3;
      rst = 1'b0;
      rd(5'd17, 5'd31);
      check("async_reset_d1", bus.data_1, 32'h0);
      check("async_reset_d2", bus.data_2, 32'h0);

      // Write attempted while reset is low, plus bypass disabled in reset
      rd(5'd3, 5'd3);
      wr(5'd3, 32'h12345678);
      @(negedge clk);
      bus.write_addr    = 5'd3;
      bus.write_data    = 32'h12345678;
      bus.write_enabled = 1'b1;
      #1;
      check("reset_no_bypass", bus.data_1, 32'h0);
      bus.write_enabled = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(i));
         check("post_reset_d1", bus.data_1, 32'h0);
         check("post_reset_d2", bus.data_2, 32'h0);
      end

      // Basic write then read on both ports
      wr(5'd5, 32'hDEADBEEF);
      rd(5'd5, 5'd5);
      check("r5_d1", bus.data_1, 32'hDEADBEEF);
      check("r5_d2", bus.data_2, 32'hDEADBEEF);
      rd(5'd6, 5'd5);
      check("r6_zero", bus.data_1, 32'h0);

      // r0 immutability, same cycle and next cycle
      wr(5'd8, 32'h88888888);
      @(negedge clk);
      bus.write_addr    = 5'd0;
      bus.write_data    = 32'hFFFFFFFF;
      bus.write_enabled = 1'b1;
      rd(5'd0, 5'd0);
      check("r0_same_cycle", bus.data_1, 32'h0);
      @(posedge clk);
      #1;
      bus.write_enabled = 1'b0;
      $display("WR r0 <= ffffffff (ignored)");
      rd(5'd0, 5'd8);
      check("r0_next_cycle", bus.data_1, 32'h0);
      check("r8_untouched", bus.data_2, 32'h88888888);

      // Bypass on port 1 only
      wr(5'd7, 32'h11111111);
      @(negedge clk);
      bus.write_addr    = 5'd7;
      bus.write_data    = 32'h22222222;
      bus.write_enabled = 1'b1;
      rd(5'd7, 5'd8);
      check("bypass_d1", bus.data_1, 32'h22222222);
      check("bypass_d2_other", bus.data_2, 32'h88888888);
      bus.write_enabled = 1'b0;
      #1;
      check("no_bypass_we0", bus.data_1, 32'h11111111);
      bus.write_enabled = 1'b1;
      @(posedge clk);
      #1;
      bus.write_enabled = 1'b0;
      $display("WR r7 <= 22222222 (bypass)");
      #1;
      check("bypass_committed", bus.data_1, 32'h22222222);

      // Both ports bypass simultaneously
      @(negedge clk);
      bus.write_addr    = 5'd9;
      bus.write_data    = 32'h33333333;
      bus.write_enabled = 1'b1;
      rd(5'd9, 5'd9);
      check("bypass_both_d1", bus.data_1, 32'h33333333);
      check("bypass_both_d2", bus.data_2, 32'h33333333);
      @(posedge clk);
      #1;
      bus.write_enabled = 1'b0;
      $display("WR r9 <= 33333333 (bypass both)");

      // Sign extension with reset high
      for (int i = 0; i < 5; i++) begin
         bus.in = ext_in[i];
         #1;
         check("sext", bus.out, ext_exp[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
